udp_tx_arbiter: RTL and testbench

//  Shares the single UDP TX engine among 3 frame requesters (0 sensor data, 1 ARP reply, 2 status).

---
 rtl/udp_tx_arbiter_pkg.sv | 30 +++
 rtl/udp_rr_pick.sv | 32 +++
 rtl/udp_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types and constants for the UDP TX arbiter: requester IDs, FSM states,
// counter width and clock-rate derived default timings.
package udp_tx_arbiter_pkg;

    localparam int unsigned N_REQ  = 3;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CNT_W  = 28;
    localparam int unsigned CLK_HZ = 125_000_000;

    // 100 us inter-frame gap and 10 ms watchdog at the system clock rate
    localparam logic [CNT_W-1:0] GAP_DEFAULT     = CNT_W'(CLK_HZ / 10_000);
    localparam logic [CNT_W-1:0] TIMEOUT_DEFAULT = CNT_W'(CLK_HZ / 100);

    localparam logic [IDX_W-1:0] REQ_SENSOR = 2'd0;
    localparam logic [IDX_W-1:0] REQ_ARP    = 2'd1;
    localparam logic [IDX_W-1:0] REQ_STATUS = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/udp_rr_pick.sv
// Combinational 3-way round-robin picker: first requester after ptr wins,
// the requester at ptr itself is considered last.
module udp_rr_pick
    import udp_tx_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] order [N_REQ];

    always_comb begin
        case (ptr)
            REQ_SENSOR: order = '{REQ_ARP, REQ_STATUS, REQ_SENSOR};
            REQ_ARP:    order = '{REQ_STATUS, REQ_SENSOR, REQ_ARP};
            default:    order = '{REQ_SENSOR, REQ_ARP, REQ_STATUS};
        endcase
        idx = '0;
        // scan from lowest priority up so the highest-priority hit is written last
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[order[k]]) begin
                idx = order[k];
            end
        end
        any = |req;
        gnt = any ? idx_onehot(idx) : '0;
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP TX engine among three frame sources,
// with start pulse, end-strobe sync, watchdog abort and inter-frame gap.
module udp_tx_arbiter
    import udp_tx_arbiter_pkg::*;
#(
    parameter logic [CNT_W-1:0] P_GAP     = GAP_DEFAULT,
    parameter logic [CNT_W-1:0] P_TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_tx_end,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_tx_sel,
    output logic             o_tx_start,
    output logic [N_REQ-1:0] o_done,
    output logic [N_REQ-1:0] o_abort,
    output logic             o_busy
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] win, win_nxt;
    logic [N_REQ-1:0] win_gnt, win_gnt_nxt;
    logic [N_REQ-1:0] gnt_nxt, done_nxt, abort_nxt;
    logic [IDX_W-1:0] sel_nxt;
    logic             start_nxt, busy_nxt;

    logic [2:0]       end_sync;
    logic             end_edge;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    udp_rr_pick u_pick (
        .req (i_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // i_tx_end may come from another domain: 3-flop sync, rising edge on the last two
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            end_sync <= '0;
        end else begin
            end_sync <= {end_sync[1:0], i_tx_end};
        end
    end

    assign end_edge = end_sync[1] & ~end_sync[2];

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        win_nxt     = win;
        win_gnt_nxt = win_gnt;
        gnt_nxt     = o_gnt;
        sel_nxt     = o_tx_sel;
        start_nxt   = 1'b0;
        done_nxt    = '0;
        abort_nxt   = '0;

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    win_nxt     = pick_idx;
                    win_gnt_nxt = pick_gnt;
                    state_nxt   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt_nxt   = win_gnt;
                sel_nxt   = win;
                state_nxt = ST_START;
            end
            ST_START: begin
                start_nxt = 1'b1;
                state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                // an end edge on the timeout cycle still counts as a completion
                if (end_edge) begin
                    done_nxt  = win_gnt;
                    ptr_nxt   = win;
                    state_nxt = ST_GAP;
                end else if (cnt >= P_TIMEOUT - CNT_W'(1)) begin
                    abort_nxt = win_gnt;
                    ptr_nxt   = win;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                gnt_nxt = '0;
                if (cnt >= P_GAP - CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
        cnt_nxt  = (state_nxt != state) ? '0 : ((&cnt) ? cnt : cnt + CNT_W'(1));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ptr        <= REQ_STATUS;
            win        <= '0;
            win_gnt    <= '0;
            o_gnt      <= '0;
            o_tx_sel   <= '0;
            o_tx_start <= 1'b0;
            o_done     <= '0;
            o_abort    <= '0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ptr        <= ptr_nxt;
            win        <= win_nxt;
            win_gnt    <= win_gnt_nxt;
            o_gnt      <= gnt_nxt;
            o_tx_sel   <= sel_nxt;
            o_tx_start <= start_nxt;
            o_done     <= done_nxt;
            o_abort    <= abort_nxt;
            o_busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: timestamp-based frame model compared every cycle,
// plus directed scenarios with hand-computed latencies and grant values.
module tb_udp_tx_arbiter;

    localparam int P_GAP     = 8;
    localparam int P_TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic [2:0] i_req = '0;
    logic       i_tx_end = 1'b0;
    logic [2:0] o_gnt;
    logic [1:0] o_tx_sel;
    logic       o_tx_start;
    logic [2:0] o_done;
    logic [2:0] o_abort;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    udp_tx_arbiter #(
        .P_GAP     (28'(P_GAP)),
        .P_TIMEOUT (28'(P_TIMEOUT))
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .i_req      (i_req),
        .i_tx_end   (i_tx_end),
        .o_gnt      (o_gnt),
        .o_tx_sel   (o_tx_sel),
        .o_tx_start (o_tx_start),
        .o_done     (o_done),
        .o_abort    (o_abort),
        .o_busy     (o_busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // ---------------- frame model: one record per frame, times in clock edges
    int         m_n   = 0;
    bit         m_act = 1'b0;
    int         m_t0  = 0;
    int         m_tf  = -1;
    int         m_win = 0;
    int         m_ptr = 2;
    logic [3:0] m_h   = '0;
    logic [2:0] e_gnt = '0, e_done = '0, e_abort = '0;
    logic [1:0] e_sel = '0;
    logic       e_start = 1'b0, e_busy = 1'b0;

    function automatic int rr_pick(input logic [2:0] req, input int ptr);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (ptr + k) % 3;
            if (req[i]) return i;
        end
        return 0;
    endfunction

    // Frame latched at edge t0: grant visible from t0+1, start pulse at t0+2 (busy entry),
    // completion at tf, idle again after tf+P_GAP; an end edge needs 3 edges of sync.
    initial forever begin
        @(posedge clk or negedge nrst);
        if (!nrst) begin
            m_n = 0; m_act = 1'b0; m_tf = -1; m_ptr = 2; m_h = '0;
            e_gnt = '0; e_sel = '0; e_start = 1'b0; e_done = '0; e_abort = '0; e_busy = 1'b0;
        end else begin
            m_n++;
            m_h = {m_h[2:0], i_tx_end};
            e_done  = '0;
            e_abort = '0;
            if (!m_act || (m_tf >= 0 && m_n > m_tf + P_GAP)) begin
                m_act = 1'b0;
                if (|i_req) begin
                    m_act = 1'b1;
                    m_t0  = m_n;
                    m_tf  = -1;
                    m_win = rr_pick(i_req, m_ptr);
                end
            end else if (m_tf < 0 && m_n >= m_t0 + 3) begin
                if (m_h[2] && !m_h[3]) begin
                    m_tf = m_n; m_ptr = m_win; e_done = 3'(1 << m_win);
                end else if (m_n - (m_t0 + 2) == P_TIMEOUT) begin
                    m_tf = m_n; m_ptr = m_win; e_abort = 3'(1 << m_win);
                end
            end
            if (m_act && m_n == m_t0 + 1) e_sel = 2'(m_win);
            e_gnt   = (m_act && m_n >= m_t0 + 1 && (m_tf < 0 || m_n <= m_tf)) ? 3'(1 << m_win) : 3'b000;
            e_start = m_act && (m_n == m_t0 + 2);
            e_busy  = m_act && (m_tf < 0 || m_n < m_tf + P_GAP);
        end
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("gnt",   32'(o_gnt),      32'(e_gnt));
        chk("sel",   32'(o_tx_sel),   32'(e_sel));
        chk("start", 32'(o_tx_start), 32'(e_start));
        chk("done",  32'(o_done),     32'(e_done));
        chk("abort", 32'(o_abort),    32'(e_abort));
        chk("busy",  32'(o_busy),     32'(e_busy));
    end

    // ---------------- directed helpers
    task automatic do_reset();
        @(posedge clk); #2;
        nrst = 1'b0; i_req = '0; i_tx_end = 1'b0;
        #1 chk("reset_outputs", 32'({o_gnt, o_tx_sel, o_tx_start, o_done, o_abort, o_busy}), 32'd0);
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
    endtask

    // which: 0 start, 1 done, 2 abort; returns the edge index of the event
    task automatic wait_evt(input int which, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which == 0 && o_tx_start) || (which == 1 && |o_done) || (which == 2 && |o_abort)) begin
                at = cyc;
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_evt%0d: no event within %0d cycles", which, limit);
    endtask

    task automatic goto_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic pulse_ack(input int dly, output int at, output logic [2:0] val);
        repeat (dly) @(posedge clk);
        #2 i_tx_end = 1'b1;
        wait_evt(1, 30, at);
        val = o_done;
        repeat (2) @(posedge clk);
        #2 i_tx_end = 1'b0;
    endtask

    initial begin
        int s, d, a, pd;
        logic [2:0] v;
        int order [4];
        order = '{0, 1, 2, 0};

        // 1: single sensor frame
        do_reset();
        @(posedge clk); #2 i_req = 3'b001;
        wait_evt(0, 10, s);
        chk("t1_gnt", 32'(o_gnt), 32'h1);
        chk("t1_sel", 32'(o_tx_sel), 32'h0);
        pulse_ack(5, d, v);
        i_req = '0;
        chk("t1_done", 32'(v), 32'h1);
        chk("t1_done_lat", 32'(d - s), 32'd8);
        goto_neg(d + 7);
        chk("t1_busy_in_gap", 32'(o_busy), 32'h1);
        goto_neg(d + 8);
        chk("t1_busy_after_gap", 32'(o_busy), 32'h0);

        // 2: all three requesting, round-robin order 0,1,2,0
        do_reset();
        @(posedge clk); #2 i_req = 3'b111;
        pd = 0;
        for (int i = 0; i < 4; i++) begin
            wait_evt(0, 40, s);
            chk("t2_sel", 32'(o_tx_sel), 32'(order[i]));
            chk("t2_gnt", 32'(o_gnt), 32'(1 << order[i]));
            if (i > 0) chk("t2_gap_respected", 32'(s - pd >= P_GAP), 32'd1);
            pulse_ack(2, pd, v);
            chk("t2_done", 32'(v), 32'(1 << order[i]));
        end
        i_req = '0;

        // 3: ARP frame never ends -> watchdog abort
        do_reset();
        @(posedge clk); #2 i_req = 3'b010;
        wait_evt(0, 10, s);
        chk("t3_sel", 32'(o_tx_sel), 32'h1);
        wait_evt(2, 60, a);
        i_req = '0;
        chk("t3_abort", 32'(o_abort), 32'h2);
        chk("t3_abort_lat", 32'(a - s), 32'(P_TIMEOUT));
        goto_neg(a + 7);
        chk("t3_busy_in_gap", 32'(o_busy), 32'h1);
        goto_neg(a + 8);
        chk("t3_idle", 32'(o_busy), 32'h0);

        // 4: end edge coincides with the timeout cycle -> done wins
        do_reset();
        @(posedge clk); #2 i_req = 3'b001;
        wait_evt(0, 10, s);
        repeat (37) @(posedge clk);
        #2 i_tx_end = 1'b1;
        wait_evt(1, 10, d);
        chk("t4_done", 32'(o_done), 32'h1);
        chk("t4_no_abort", 32'(o_abort), 32'h0);
        chk("t4_done_lat", 32'(d - s), 32'(P_TIMEOUT));
        i_req = '0;
        repeat (2) @(posedge clk);
        #2 i_tx_end = 1'b0;
        goto_neg(d + 10);

        // 5: end pulse while idle is ignored; req dropped mid-BUSY still completes
        do_reset();
        @(posedge clk); #2 i_tx_end = 1'b1;
        repeat (4) @(posedge clk);
        #2 i_tx_end = 1'b0;
        repeat (3) @(posedge clk);
        #2 i_req = 3'b001;
        wait_evt(0, 10, s);
        chk("t5_gnt", 32'(o_gnt), 32'h1);
        @(posedge clk); #2 i_req = '0;
        pulse_ack(2, d, v);
        chk("t5_done", 32'(v), 32'h1);
        goto_neg(d + 10);

        // 6: reset mid-BUSY, then status request served normally
        do_reset();
        @(posedge clk); #2 i_req = 3'b001;
        wait_evt(0, 10, s);
        repeat (4) @(negedge clk);
        do_reset();
        @(posedge clk); #2 i_req = 3'b100;
        wait_evt(0, 10, s);
        chk("t6_gnt", 32'(o_gnt), 32'h4);
        chk("t6_sel", 32'(o_tx_sel), 32'h2);
        pulse_ack(3, d, v);
        i_req = '0;
        chk("t6_done", 32'(v), 32'h4);
        goto_neg(d + 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
